// File: rtl/wb_trace_buffer_if.sv
// Bundles the datapath retirement strobes and the trace drain port of the
// retirement trace buffer. The buffer uses the slave view. The driving side
// (datapath plus trace consumer) uses the master view.
interface wb_trace_buffer_if #(
    parameter int DATA_WIDTH        = 32,
    parameter int MEM_ADDRESS_WIDTH = 9,
    parameter int SEQ_WIDTH         = 16
);
    // Writeback debug outputs of the datapath
    logic                         RegWriteSignal;
    logic [4:0]                   RegNum;
    logic [DATA_WIDTH-1:0]        RegData;

    // Data-memory store outputs of the datapath
    logic                         WriteEnable;
    logic [MEM_ADDRESS_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0]        WRData;

    // Trace drain port (valid/ready)
    logic                         trace_ready;
    logic                         trace_valid;
    logic                         trace_kind;
    logic [MEM_ADDRESS_WIDTH-1:0] trace_idx;
    logic [DATA_WIDTH-1:0]        trace_data;
    logic [SEQ_WIDTH-1:0]         trace_seq;

    modport slave (
        input  RegWriteSignal, RegNum, RegData,
        input  WriteEnable, Address, WRData,
        input  trace_ready,
        output trace_valid, trace_kind, trace_idx, trace_data, trace_seq
    );

    modport master (
        output RegWriteSignal, RegNum, RegData,
        output WriteEnable, Address, WRData,
        output trace_ready,
        input  trace_valid, trace_kind, trace_idx, trace_data, trace_seq
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// Retirement trace buffer. It captures register writebacks and memory stores
// from the pipeline and tags each one with a sequence number. The tagged
// records are queued in a FIFO, and the FIFO drains over a valid/ready port.
// A same-cycle register write is older than a same-cycle store, so it is
// queued first.
module wb_trace_buffer #(
    parameter  int DATA_WIDTH        = 32,
    parameter  int MEM_ADDRESS_WIDTH = 9,
    parameter  int DEPTH             = 16,
    parameter  int SEQ_WIDTH         = 16,
    localparam int FILL_W            = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    wb_trace_buffer_if.slave     bus,
    output logic [FILL_W-1:0]    fill,
    output logic                 full,
    output logic [SEQ_WIDTH-1:0] drop_count,
    output logic [SEQ_WIDTH-1:0] event_count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = 1 + MEM_ADDRESS_WIDTH + DATA_WIDTH + SEQ_WIDTH;

    // Record layout, MSB first: kind | idx | data | seq
    logic [REC_W-1:0]       r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [FILL_W-1:0]      r_fill;
    logic [SEQ_WIDTH-1:0]   r_seq;
    logic [SEQ_WIDTH-1:0]   r_drop_count;
    logic [SEQ_WIDTH-1:0]   r_event_count;

    logic                   w_ev_r;
    logic                   w_ev_m;
    logic                   w_valid;
    logic                   w_pop;
    logic [FILL_W-1:0]      w_free;
    logic                   w_push_r;
    logic                   w_push_m;
    logic [1:0]             w_n_ev;
    logic [1:0]             w_n_push;
    logic [1:0]             w_n_drop;
    logic [AW-1:0]          w_wr_ptr_m;
    logic [REC_W-1:0]       w_rec_r;
    logic [REC_W-1:0]       w_rec_m;
    logic [REC_W-1:0]       w_head;
    logic [SEQ_WIDTH:0]     w_ev_sum;
    logic [SEQ_WIDTH:0]     w_drop_sum;
    logic [SEQ_WIDTH-1:0]   w_event_count_next;
    logic [SEQ_WIDTH-1:0]   w_drop_count_next;

    // Event qualification and push/drop arbitration. A pop in the same cycle
    // frees a slot. The register write claims the first free slot.
    always_comb begin
        w_ev_r     = bus.RegWriteSignal && (bus.RegNum != 5'd0);
        w_ev_m     = bus.WriteEnable;
        w_valid    = (r_fill != '0);
        w_pop      = w_valid && bus.trace_ready;
        w_free     = FILL_W'(DEPTH) - r_fill + FILL_W'(w_pop);
        w_push_r   = w_ev_r && (w_free != '0);
        w_push_m   = w_ev_m && (w_ev_r ? (w_free >= FILL_W'(2)) : (w_free != '0));
        w_n_ev     = {1'b0, w_ev_r} + {1'b0, w_ev_m};
        w_n_push   = {1'b0, w_push_r} + {1'b0, w_push_m};
        w_n_drop   = w_n_ev - w_n_push;
        w_wr_ptr_m = r_wr_ptr + AW'(w_push_r);
    end

    // Record assembly. The store takes the next sequence number after a
    // qualifying register write, even when that write was dropped.
    always_comb begin
        w_rec_r = {1'b0, MEM_ADDRESS_WIDTH'(bus.RegNum), bus.RegData, r_seq};
        w_rec_m = {1'b1, bus.Address, bus.WRData, r_seq + SEQ_WIDTH'(w_ev_r)};
    end

    // Saturating event and drop counters. They stick at all-ones and never wrap.
    always_comb begin
        w_ev_sum           = {1'b0, r_event_count} + (SEQ_WIDTH + 1)'(w_n_ev);
        w_drop_sum         = {1'b0, r_drop_count} + (SEQ_WIDTH + 1)'(w_n_drop);
        w_event_count_next = w_ev_sum[SEQ_WIDTH] ? '1 : w_ev_sum[SEQ_WIDTH-1:0];
        w_drop_count_next  = w_drop_sum[SEQ_WIDTH] ? '1 : w_drop_sum[SEQ_WIDTH-1:0];
    end

    // Record storage. It has no reset because occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (!clr) begin
            if (w_push_r) begin
                r_mem[r_wr_ptr] <= w_rec_r;
            end
            if (w_push_m) begin
                r_mem[w_wr_ptr_m] <= w_rec_m;
            end
        end
    end

    // Pointers, occupancy, sequence number and counters. clr has top priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fill        <= '0;
            r_seq         <= '0;
            r_drop_count  <= '0;
            r_event_count <= '0;
        end else if (clr) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fill        <= '0;
            r_seq         <= '0;
            r_drop_count  <= '0;
            r_event_count <= '0;
        end else begin
            r_wr_ptr      <= r_wr_ptr + AW'(w_n_push);
            r_rd_ptr      <= r_rd_ptr + AW'(w_pop);
            r_fill        <= r_fill + FILL_W'(w_n_push) - FILL_W'(w_pop);
            r_seq         <= r_seq + SEQ_WIDTH'(w_n_ev);
            r_drop_count  <= w_drop_count_next;
            r_event_count <= w_event_count_next;
        end
    end

    // Head record is read combinationally. The outputs are zero while the FIFO is empty.
    always_comb begin
        w_head         = r_mem[r_rd_ptr];
        bus.trace_valid = w_valid;
        bus.trace_kind  = 1'b0;
        bus.trace_idx   = '0;
        bus.trace_data  = '0;
        bus.trace_seq   = '0;
        if (w_valid) begin
            {bus.trace_kind, bus.trace_idx, bus.trace_data, bus.trace_seq} = w_head;
        end
    end

    // Status outputs
    always_comb begin
        fill        = r_fill;
        full        = (r_fill == FILL_W'(DEPTH));
        drop_count  = r_drop_count;
        event_count = r_event_count;
    end
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer. A queue model follows the trace rules
// one event at a time and is compared on every falling edge. Hand-computed
// literals at key points pin the model.
module tb_wb_trace_buffer;
    localparam int DW    = 32;
    localparam int MAW   = 9;
    localparam int DEPTH = 16;
    localparam int SW    = 16;
    localparam int FW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic [FW-1:0] fill;
    logic          full;
    logic [SW-1:0] drop_count;
    logic [SW-1:0] event_count;

    int total = 0;
    int bad   = 0;

    wb_trace_buffer_if #(.DATA_WIDTH(DW), .MEM_ADDRESS_WIDTH(MAW), .SEQ_WIDTH(SW)) tif ();

    wb_trace_buffer #(
        .DATA_WIDTH(DW), .MEM_ADDRESS_WIDTH(MAW), .DEPTH(DEPTH), .SEQ_WIDTH(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .bus(tif),
        .fill(fill),
        .full(full),
        .drop_count(drop_count),
        .event_count(event_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit              kind;
        int unsigned     idx;
        logic [DW-1:0]   data;
        int unsigned     seq;
    } rec_t;

    rec_t        mq[$];
    int unsigned m_seq    = 0;
    int unsigned m_events = 0;
    int unsigned m_drops  = 0;

    function automatic int unsigned sat(input int unsigned v);
        return (v > 32'hFFFF) ? 32'hFFFF : v;
    endfunction

    task automatic accept(input bit kind, input int unsigned idx, input logic [DW-1:0] data);
        rec_t r;
        r.kind = kind;
        r.idx  = idx;
        r.data = data;
        r.seq  = m_seq;
        m_events++;
        if (mq.size() < DEPTH) mq.push_back(r);
        else begin
            m_drops++;
            $display("[%0t] drop kind=%0d seq=%0d", $time, kind, m_seq);
        end
        m_seq = (m_seq + 1) & 32'hFFFF;
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst || clr) begin
            mq.delete();
            m_seq = 0;
            m_events = 0;
            m_drops = 0;
        end else begin
            if (mq.size() > 0 && tif.trace_ready) begin
                $display("[%0t] pop kind=%0d idx=%0h data=%08h seq=%0d",
                         $time, mq[0].kind, mq[0].idx, mq[0].data, mq[0].seq);
                void'(mq.pop_front());
            end
            if (tif.RegWriteSignal && tif.RegNum != 5'd0)
                accept(1'b0, int'(tif.RegNum), tif.RegData);
            if (tif.WriteEnable)
                accept(1'b1, int'(tif.Address), tif.WRData);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        chk("valid", tif.trace_valid, longint'(mq.size() != 0));
        chk("fill", fill, mq.size());
        chk("full", full, longint'(mq.size() == DEPTH));
        chk("drop_count", drop_count, sat(m_drops));
        chk("event_count", event_count, sat(m_events));
        if (mq.size() != 0) begin
            chk("kind", tif.trace_kind, mq[0].kind);
            chk("idx", tif.trace_idx, mq[0].idx);
            chk("data", tif.trace_data, mq[0].data);
            chk("seq", tif.trace_seq, mq[0].seq);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit r, input logic [4:0] rn, input logic [DW-1:0] rd,
                         input bit m, input logic [MAW-1:0] a, input logic [DW-1:0] wd);
        tif.RegWriteSignal = r;
        tif.RegNum         = rn;
        tif.RegData        = rd;
        tif.WriteEnable    = m;
        tif.Address        = a;
        tif.WRData         = wd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, '0, 1'b0, '0, '0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic fill_regs(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 5'((i % 31) + 1), DW'(i * 32'h101), 1'b0, '0, '0);
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        tif.trace_ready = 1'b0;

        // Reset and idle
        repeat (3) tick();
        chk("rst_valid", tif.trace_valid, 0);
        chk("rst_fill", fill, 0);
        chk("rst_events", event_count, 0);
        chk("rst_drops", drop_count, 0);
        chk("rst_data", tif.trace_data, 0);
        rst = 1'b1;
        repeat (2) tick();
        chk("idle_valid", tif.trace_valid, 0);

        // Single register write, held until ready
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        tick();
        idle();
        chk("t2_valid", tif.trace_valid, 1);
        chk("t2_kind", tif.trace_kind, 0);
        chk("t2_idx", tif.trace_idx, 5);
        chk("t2_data", tif.trace_data, 32'hDEADBEEF);
        chk("t2_seq", tif.trace_seq, 0);
        repeat (3) tick();
        chk("t2_hold_data", tif.trace_data, 32'hDEADBEEF);
        chk("t2_hold_idx", tif.trace_idx, 5);
        tif.trace_ready = 1'b1;
        tick();
        tif.trace_ready = 1'b0;
        chk("t2_popped", tif.trace_valid, 0);
        chk("t2_events", event_count, 1);

        // Dual event, then x0 writes
        do_clr();
        chk("clr_events", event_count, 0);
        drive(1'b1, 5'd3, 32'h11, 1'b1, 9'h1F4, 32'h22);
        tick();
        idle();
        chk("t3_fill", fill, 2);
        chk("t3_seq0", tif.trace_seq, 0);
        chk("t3_idx0", tif.trace_idx, 3);
        tif.trace_ready = 1'b1;
        tick();
        tif.trace_ready = 1'b0;
        chk("t3_kind1", tif.trace_kind, 1);
        chk("t3_idx1", tif.trace_idx, 9'h1F4);
        chk("t3_data1", tif.trace_data, 32'h22);
        chk("t3_seq1", tif.trace_seq, 1);
        drive(1'b1, 5'd0, 32'h99, 1'b0, '0, '0);
        tick();
        idle();
        chk("t3_x0_events", event_count, 2);
        chk("t3_x0_fill", fill, 1);
        drive(1'b1, 5'd0, 32'h98, 1'b1, 9'h010, 32'h33);
        tick();
        idle();
        chk("t3_x0m_events", event_count, 3);
        chk("t3_x0m_fill", fill, 2);
        tif.trace_ready = 1'b1;
        repeat (2) tick();
        tif.trace_ready = 1'b0;
        chk("t3_drained", fill, 0);

        // Overflow
        do_clr();
        fill_regs(DEPTH + 2);
        chk("t4_full", full, 1);
        chk("t4_fill", fill, 16);
        chk("t4_drops", drop_count, 2);
        chk("t4_events", event_count, 18);
        chk("t4_head_seq", tif.trace_seq, 0);
        tif.trace_ready = 1'b1;
        repeat (15) tick();
        chk("t4_last_seq", tif.trace_seq, 15);
        tick();
        tif.trace_ready = 1'b0;
        chk("t4_empty", fill, 0);

        // Full with pop plus dual event
        do_clr();
        fill_regs(DEPTH);
        chk("t5_full", full, 1);
        tif.trace_ready = 1'b1;
        drive(1'b1, 5'd7, 32'hAA, 1'b1, 9'h020, 32'hBB);
        tick();
        tif.trace_ready = 1'b0;
        idle();
        chk("t5_fill", fill, 16);
        chk("t5_drops", drop_count, 1);
        chk("t5_events", event_count, 18);
        chk("t5_head_seq", tif.trace_seq, 1);
        tif.trace_ready = 1'b1;
        repeat (15) tick();
        chk("t5_tail_seq", tif.trace_seq, 16);
        chk("t5_tail_idx", tif.trace_idx, 7);
        chk("t5_tail_data", tif.trace_data, 32'hAA);
        tick();
        tif.trace_ready = 1'b0;
        chk("t5_empty", tif.trace_valid, 0);

        // Asynchronous reset mid-stream, then clr at an edge
        do_clr();
        fill_regs(5);
        chk("t6_fill5", fill, 5);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_valid", tif.trace_valid, 0);
        chk("t6_async_fill", fill, 0);
        chk("t6_async_data", tif.trace_data, 0);
        chk("t6_async_events", event_count, 0);
        #1 rst = 1'b1;
        drive(1'b1, 5'd9, 32'h55, 1'b0, '0, '0);
        tick();
        idle();
        chk("t6_seq_after_rst", tif.trace_seq, 0);
        chk("t6_events_after_rst", event_count, 1);
        fill_regs(3);
        drive(1'b1, 5'd4, 32'h44, 1'b1, 9'h004, 32'h45);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        idle();
        chk("t6_clr_valid", tif.trace_valid, 0);
        chk("t6_clr_fill", fill, 0);
        chk("t6_clr_events", event_count, 0);
        drive(1'b1, 5'd6, 32'h66, 1'b0, '0, '0);
        tick();
        idle();
        chk("t6_seq_after_clr", tif.trace_seq, 0);
        chk("t6_idx_after_clr", tif.trace_idx, 6);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
